// File: rtl/pipe_fwd_scoreboard.sv
// Forwarding/interlock scoreboard: tracks in-flight register writes
// from issue to write-back and picks RF, forward stage, or stall per read port.
module pipe_fwd_scoreboard #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 3,
    parameter int NRD    = 2,
    parameter int CNT_W  = 32,
    localparam int SELW  = $clog2(DEPTH + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NRD-1:0]           i_rd_en,
    input  logic [5*NRD-1:0]         i_rd_addr,
    input  logic [DATA_W*NRD-1:0]    i_rf_data,
    input  logic [DATA_W*DEPTH-1:0]  i_stage_data,
    input  logic                     i_issue_valid,
    input  logic                     i_issue_wreg,
    input  logic [4:0]               i_issue_wn,
    input  logic [SELW-1:0]          i_issue_rdy,
    input  logic                     i_flush,
    input  logic                     i_hold,
    output logic [DATA_W*NRD-1:0]    o_rd_data,
    output logic [SELW*NRD-1:0]      o_rd_sel,
    output logic                     o_stall,
    output logic [CNT_W-1:0]         o_stall_cnt,
    output logic [CNT_W-1:0]         o_fwd_cnt
);

    logic [DEPTH-1:0]           r_v;
    logic [DEPTH-1:0][4:0]      r_wn;
    logic [DEPTH-1:0][SELW-1:0] r_rdy;
    logic [CNT_W-1:0]           r_stall_cnt;
    logic [CNT_W-1:0]           r_fwd_cnt;

    logic [DATA_W*NRD-1:0] w_rd_data;
    logic [SELW*NRD-1:0]   w_rd_sel;
    logic [NRD-1:0]        w_blk;
    logic                  w_stall;
    logic                  w_adv;
    logic                  w_new_v;
    logic [CNT_W:0]        w_nfwd;
    logic [CNT_W:0]        w_fwd_sum;
    logic [CNT_W-1:0]      w_fwd_next;

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        w_rd_sel  = '0;
        w_rd_data = i_rf_data;
        w_blk     = '0;
        for (int i = 0; i < NRD; i++) begin
            if (i_rd_en[i] && (i_rd_addr[5*i +: 5] != 5'd0)) begin
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    if (r_v[k] && (r_wn[k] == i_rd_addr[5*i +: 5])) begin
                        if (SELW'(k + 1) >= r_rdy[k]) begin
                            w_rd_sel[SELW*i +: SELW] = SELW'(k + 1);
                            w_rd_data[DATA_W*i +: DATA_W] =
                                i_stage_data[DATA_W*k +: DATA_W];
                            w_blk[i] = 1'b0;
                        end else begin
                            w_rd_sel[SELW*i +: SELW] = '0;
                            w_rd_data[DATA_W*i +: DATA_W] =
                                i_rf_data[DATA_W*i +: DATA_W];
                            w_blk[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        w_nfwd = '0;
        for (int i = 0; i < NRD; i++) begin
            if (w_rd_sel[SELW*i +: SELW] != '0) begin
                w_nfwd = w_nfwd + (CNT_W + 1)'(1);
            end
        end
    end

    assign w_stall    = i_hold | (i_issue_valid & (|w_blk));
    assign w_adv      = i_issue_valid & ~w_stall & ~i_flush;
    assign w_new_v    = w_adv & i_issue_wreg & (i_issue_wn != 5'd0);
    assign w_fwd_sum  = {1'b0, r_fwd_cnt} + w_nfwd;
    assign w_fwd_next = w_fwd_sum[CNT_W] ? '1 : w_fwd_sum[CNT_W-1:0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_v         <= '0;
            r_wn        <= '0;
            r_rdy       <= '0;
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            if (!i_hold) begin
                r_v   <= {r_v[DEPTH-2:0], w_new_v};
                r_wn  <= {r_wn[DEPTH-2:0], i_issue_wn};
                r_rdy <= {r_rdy[DEPTH-2:0], i_issue_rdy};
            end
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_adv) begin
                r_fwd_cnt <= w_fwd_next;
            end
        end
    end

    assign o_rd_data   = w_rd_data;
    assign o_rd_sel    = w_rd_sel;
    assign o_stall     = w_stall;
    assign o_stall_cnt = r_stall_cnt;
    assign o_fwd_cnt   = r_fwd_cnt;

endmodule

// File: tb/tb_pipe_fwd_scoreboard.sv
// Directed bench for pipe_fwd_scoreboard (DEPTH=3, NRD=2, CNT_W=3).
// Inputs change 1 time unit after the rising edge; outputs sampled 1 unit later.
module tb_pipe_fwd_scoreboard;

    localparam int DW = 32;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    rd_en;
    logic [9:0]    rd_addr;
    logic [63:0]   rf_data;
    logic [95:0]   stage_data;
    logic          issue_valid;
    logic          issue_wreg;
    logic [4:0]    issue_wn;
    logic [SW-1:0] issue_rdy;
    logic          flush;
    logic          hold;
    logic [63:0]   rd_data;
    logic [3:0]    rd_sel;
    logic          stall;
    logic [2:0]    stall_cnt;
    logic [2:0]    fwd_cnt;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [31:0] RF0 = 32'hAAAA0000;
    localparam logic [31:0] RF1 = 32'hBBBB0000;

    pipe_fwd_scoreboard #(
        .DATA_W(DW), .DEPTH(3), .NRD(2), .CNT_W(3)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_rd_en(rd_en),
        .i_rd_addr(rd_addr),
        .i_rf_data(rf_data),
        .i_stage_data(stage_data),
        .i_issue_valid(issue_valid),
        .i_issue_wreg(issue_wreg),
        .i_issue_wn(issue_wn),
        .i_issue_rdy(issue_rdy),
        .i_flush(flush),
        .i_hold(hold),
        .o_rd_data(rd_data),
        .o_rd_sel(rd_sel),
        .o_stall(stall),
        .o_stall_cnt(stall_cnt),
        .o_fwd_cnt(fwd_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic iss(input logic v, input logic w, input logic [4:0] wn,
                       input logic [SW-1:0] r);
        issue_valid = v;
        issue_wreg  = w;
        issue_wn    = wn;
        issue_rdy   = r;
    endtask

    task automatic rd(input logic [1:0] en, input logic [4:0] a0,
                      input logic [4:0] a1);
        rd_en   = en;
        rd_addr = {a1, a0};
    endtask

    task automatic idle();
        iss(1'b0, 1'b0, 5'd0, 2'd1);
        rd(2'b00, 5'd0, 5'd0);
        flush = 1'b0;
        hold  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rf_data    = {RF1, RF0};
        stage_data = {32'h33, 32'h22, 32'h11};
        idle();

        // reset state: stall follows hold
        rst  = 1'b1;
        hold = 1'b1;
        rd(2'b11, 5'd3, 5'd4);
        #1;
        chk("rst_stall_hold", 64'(stall), 64'd1);
        chk("rst_sel", 64'(rd_sel), 64'd0);
        chk("rst_data", rd_data, {RF1, RF0});
        chk("rst_scnt", 64'(stall_cnt), 64'd0);
        chk("rst_fcnt", 64'(fwd_cnt), 64'd0);
        do_reset();

        // ALU chain
        iss(1'b1, 1'b1, 5'd3, 2'd1);
        #1;
        chk("alu_issue_stall", 64'(stall), 64'd0);
        tick();
        iss(1'b1, 1'b0, 5'd0, 2'd1);
        rd(2'b01, 5'd3, 5'd0);
        #1;
        chk("alu_stall", 64'(stall), 64'd0);
        chk("alu_sel1", 64'(rd_sel[1:0]), 64'd1);
        chk("alu_data1", 64'(rd_data[31:0]), 64'h11);
        tick();
        iss(1'b0, 1'b0, 5'd0, 2'd1);
        #1;
        chk("alu_sel2", 64'(rd_sel[1:0]), 64'd2);
        chk("alu_data2", 64'(rd_data[31:0]), 64'h22);
        tick();
        #1;
        chk("alu_sel3", 64'(rd_sel[1:0]), 64'd3);
        chk("alu_data3", 64'(rd_data[31:0]), 64'h33);
        tick();
        #1;
        chk("alu_sel0", 64'(rd_sel[1:0]), 64'd0);
        chk("alu_data0", 64'(rd_data[31:0]), 64'(RF0));
        chk("alu_fcnt", 64'(fwd_cnt), 64'd1);

        // load-use
        do_reset();
        iss(1'b1, 1'b1, 5'd4, 2'd2);
        tick();
        iss(1'b1, 1'b0, 5'd0, 2'd1);
        rd(2'b01, 5'd4, 5'd0);
        #1;
        chk("lu_stall", 64'(stall), 64'd1);
        chk("lu_sel_blk", 64'(rd_sel[1:0]), 64'd0);
        tick();
        #1;
        chk("lu_stall_done", 64'(stall), 64'd0);
        chk("lu_sel2", 64'(rd_sel[1:0]), 64'd2);
        chk("lu_data2", 64'(rd_data[31:0]), 64'h22);
        chk("lu_scnt", 64'(stall_cnt), 64'd1);
        tick();
        idle();
        #1;
        chk("lu_fcnt", 64'(fwd_cnt), 64'd1);

        // multi-cycle producer with hold
        do_reset();
        iss(1'b1, 1'b1, 5'd5, 2'd3);
        tick();
        iss(1'b1, 1'b0, 5'd0, 2'd1);
        rd(2'b01, 5'd5, 5'd0);
        #1;
        chk("mc_stall_b", 64'(stall), 64'd1);
        tick();
        hold = 1'b1;
        #1;
        chk("mc_stall_h1", 64'(stall), 64'd1);
        tick();
        #1;
        chk("mc_stall_h2", 64'(stall), 64'd1);
        tick();
        hold = 1'b0;
        #1;
        chk("mc_stall_e", 64'(stall), 64'd1);
        tick();
        #1;
        chk("mc_stall_f", 64'(stall), 64'd0);
        chk("mc_sel3", 64'(rd_sel[1:0]), 64'd3);
        chk("mc_data3", 64'(rd_data[31:0]), 64'h33);
        chk("mc_scnt", 64'(stall_cnt), 64'd4);

        // youngest wins, r0 never matches
        do_reset();
        iss(1'b1, 1'b1, 5'd6, 2'd1);
        tick();
        tick();
        iss(1'b1, 1'b0, 5'd0, 2'd1);
        rd(2'b11, 5'd6, 5'd6);
        #1;
        chk("yw_sel", 64'(rd_sel), 64'h5);
        chk("yw_data", rd_data, {32'h11, 32'h11});
        chk("yw_stall", 64'(stall), 64'd0);
        tick();
        iss(1'b1, 1'b1, 5'd0, 2'd1);
        rd(2'b00, 5'd0, 5'd0);
        #1;
        chk("yw_fcnt", 64'(fwd_cnt), 64'd2);
        tick();
        iss(1'b1, 1'b0, 5'd0, 2'd1);
        rd(2'b11, 5'd0, 5'd0);
        #1;
        chk("r0_sel", 64'(rd_sel), 64'd0);
        chk("r0_data", rd_data, {RF1, RF0});

        // flush
        do_reset();
        iss(1'b1, 1'b1, 5'd8, 2'd1);
        tick();
        iss(1'b1, 1'b0, 5'd0, 2'd1);
        rd(2'b01, 5'd8, 5'd0);
        flush = 1'b1;
        #1;
        chk("fl_fwd_sel", 64'(rd_sel[1:0]), 64'd1);
        tick();
        iss(1'b1, 1'b1, 5'd7, 2'd1);
        rd(2'b00, 5'd0, 5'd0);
        flush = 1'b1;
        tick();
        iss(1'b1, 1'b0, 5'd0, 2'd1);
        rd(2'b10, 5'd0, 5'd7);
        flush = 1'b0;
        #1;
        chk("fl_sel", 64'(rd_sel), 64'd0);
        chk("fl_stall", 64'(stall), 64'd0);
        chk("fl_data", 64'(rd_data[63:32]), 64'(RF1));
        tick();
        #1;
        chk("fl_fcnt", 64'(fwd_cnt), 64'd0);

        // async reset mid-stall
        do_reset();
        iss(1'b1, 1'b1, 5'd4, 2'd3);
        tick();
        iss(1'b1, 1'b0, 5'd0, 2'd1);
        rd(2'b01, 5'd4, 5'd0);
        #1;
        chk("ar_stall", 64'(stall), 64'd1);
        tick();
        #1;
        chk("ar_scnt", 64'(stall_cnt), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_stall_rst", 64'(stall), 64'd0);
        chk("ar_scnt_rst", 64'(stall_cnt), 64'd0);
        chk("ar_sel_rst", 64'(rd_sel), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("ar_stall_after", 64'(stall), 64'd0);

        // stall counter saturation
        do_reset();
        hold = 1'b1;
        for (int n = 0; n < 6; n++) tick();
        #1;
        chk("sat_scnt6", 64'(stall_cnt), 64'd6);
        for (int n = 0; n < 3; n++) tick();
        #1;
        chk("sat_scnt9", 64'(stall_cnt), 64'd7);

        // forward counter saturation: 2 forwards per cycle
        do_reset();
        iss(1'b1, 1'b1, 5'd1, 2'd1);
        tick();
        rd(2'b11, 5'd1, 5'd1);
        for (int n = 0; n < 3; n++) tick();
        #1;
        chk("sat_fcnt6", 64'(fwd_cnt), 64'd6);
        tick();
        #1;
        chk("sat_fcnt8", 64'(fwd_cnt), 64'd7);

        idle();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
